cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Single owner of the shared `memory4c` main-memory port. It arbitrates between I-cache miss fills, D-cache miss fills and D-side write-through stores. For fills it sequences the 8-word block read, streams returned words into the requesting cache's data array and commits the tag. It raises per-side stall signals that hold the pipeline until its request is complete.

## Interface
- WORDS, 8, words per cache block; power of two; `fill_word` width is log2(WORDS); block = WORDS×2 bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- I_miss  in  1  I-cache miss; held high by requester until `I_done`.
- I_addr  in  16  I-side miss byte address (PC).
- D_miss  in  1  D-cache load miss; held until `D_done`.
- D_wr  in  1  D-side store (write-through, no write-allocate); held until `D_done`.
- D_addr  in  16  D-side byte address for miss or store.
- D_wdata  in  16  store data.
- mem_data_out  in  16  main-memory read data.
- mem_data_valid  in  1  main-memory read data valid.
- mem_en  out  1  main-memory enable.
- mem_wr  out  1  main-memory write.
- mem_addr  out  16  main-memory byte address.
- mem_data_in  out  16  main-memory write data.
- fill_data  out  16  word to write into a cache data array (= mem_data_out).
- fill_word  out  log2(WORDS)  word index within block for current fill write.
- I_data_we / D_data_we  out  1  cache data-array write strobe.
- I_tag_we / D_tag_we  out  1  cache tag-array write strobe.
- I_stall / D_stall  out  1  requester must hold; feeds pipeline stall logic.
- I_done / D_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WRITE, FILL, TAG. The grant owner (I or D) and block base address (addr & ~(2·WORDS−1)) are latched on leaving IDLE.
- IDLE: the priority is D_wr, then D_miss, then I_miss.
  - D_wr goes to WRITE.
  - D_miss goes to FILL with owner=D.
  - I_miss goes to FILL with owner=I.
  - No request stays in IDLE.
  - D-side goes first because the MEM-stage instruction is older than the fetch.
- Arbitration happens only in IDLE. Requests arriving or changing mid-service are not examined until the return to IDLE.
- WRITE (1 cycle):
  - Drive mem_en=1, mem_wr=1, mem_addr=D_addr, mem_data_in=D_wdata.
  - Pulse D_done, then go to IDLE.
- FILL:
  - Issue counter `iss` runs 0..WORDS−1. Each FILL cycle with iss<WORDS drives mem_en=1, mem_wr=0, mem_addr=base+2·iss, then increments iss. One read is issued per cycle.
  - Return counter `ret` tracks returned words. Each cycle with mem_data_valid asserts the owner's data_we, with fill_word=ret and fill_data=mem_data_out, then increments ret.
  - When ret=WORDS−1 and mem_data_valid are both true, go to TAG.
- TAG (1 cycle):
  - Assert the owner's tag_we with fill_word=0.
  - Pulse the owner's done.
  - Clear iss and ret, then go to IDLE.
- I_stall = I_miss & ~I_done.
- D_stall = (D_miss | D_wr) & ~D_done.
- Stalls are combinational, so they assert in the same cycle the request rises.
- Outside FILL:
  - mem_data_valid is ignored and no data_we asserts.
  - mem_en=0, mem_wr=0; mem_addr and mem_data_in are 0.
- Only the owner's strobes ever assert. The other side's data_we and tag_we stay 0.

## Timing
- Reset (async, rst_n low): state=IDLE, iss=ret=0, owner=I. All strobes, done pulses, mem_en and mem_wr are 0; mem_addr=mem_data_in=0; fill_word=0.
  - Stalls follow their inputs even during reset.
  - Reset mid-fill abandons the fill with no tag write. Late mem_data_valid pulses after reset are ignored.
- Store: request seen in IDLE at cycle t, memory write at t+1, D_done at t+1, IDLE at t+2.
- Fill with memory read latency L (memory4c: L=4):
  - Request seen at t, issues at t+1..t+WORDS.
  - Data writes occur at t+1+L..t+L+WORDS.
  - TAG and done occur at t+L+WORDS+1; with WORDS=8 and L=4 that is t+13.
- Back-to-back: a held request is seen in the IDLE cycle after done. Requesters drop the request in the cycle after done, so no double service.
- D_wr and D_miss together: the store is serviced first and the fill follows. The unit driving them must never assert both.
- Address wrap: base+2·iss is computed mod 2^16. Block 0xFFF0 issues 0xFFF0..0xFFFE.

## Test plan
- Reset mid-fill: assert rst_n=0 at FILL with ret=3 → all outputs reach reset values immediately. A subsequent valid pulse causes no data_we and no tag_we.
- I fill: I_miss=1, I_addr=0x0046 at t → mem_addr 0x0040..0x004E at t+1..t+8.
  - I_data_we at t+5..t+12 with fill_word 0..7.
  - I_tag_we and I_done at t+13; I_stall high t..t+12; D-side strobes stay 0.
- Store: D_wr=1, D_addr=0x1234, D_wdata=0xBEEF → t+1 shows mem_en=1, mem_wr=1, addr 0x1234, data 0xBEEF and D_done=1. No fill and no tag write.
- Contention: I_miss and D_miss rise together at t → D fill first, with D_done at t+13. I_stall stays high throughout; I fill starts t+14 and I_done arrives at t+27.
- Mid-service arrival: D_wr rises during an I fill → ignored until IDLE. The I fill completes unchanged, and the store issues in the cycle after I_done+1.
- Wrap: D_miss at D_addr=0xFFF8 → reads 0xFFF0..0xFFFE, with D_tag_we at t+13.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: sole owner of the shared main-memory port. Serialises
// D-side write-through stores, D-cache block fills and I-cache block fills,
// streams returned words into the owning cache and commits its tag.
module cache_mem_arbiter #(
    parameter int unsigned WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     I_miss,
    input  logic [15:0]              I_addr,
    input  logic                     D_miss,
    input  logic                     D_wr,
    input  logic [15:0]              D_addr,
    input  logic [15:0]              D_wdata,
    input  logic [15:0]              mem_data_out,
    input  logic                     mem_data_valid,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_data_in,
    output logic [15:0]              fill_data,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     I_data_we,
    output logic                     D_data_we,
    output logic                     I_tag_we,
    output logic                     D_tag_we,
    output logic                     I_stall,
    output logic                     D_stall,
    output logic                     I_done,
    output logic                     D_done
);

    localparam int unsigned WordW = $clog2(WORDS);
    // One extra bit so the issue counter can reach WORDS and stop issuing.
    localparam int unsigned CntW  = WordW + 1;

    localparam logic [15:0]     BlockMask = ~(16'(2 * WORDS) - 16'd1);
    localparam logic [CntW-1:0] IssEnd    = CntW'(WORDS);
    localparam logic [CntW-1:0] RetLast   = CntW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StFill, StTag} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;  // 1: D side, 0: I side
    logic [15:0]     base_q, base_d;
    logic [CntW-1:0] iss_q, iss_d;
    logic [CntW-1:0] ret_q, ret_d;

    // State, grant owner, block base and fill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            base_q  <= 16'd0;
            iss_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
        end
    end

    // Arbitration, fill sequencing and memory/cache strobes.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        iss_d       = iss_q;
        ret_d       = ret_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'd0;
        mem_data_in = 16'd0;
        fill_word   = '0;
        I_data_we   = 1'b0;
        D_data_we   = 1'b0;
        I_tag_we    = 1'b0;
        D_tag_we    = 1'b0;
        I_done      = 1'b0;
        D_done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // D side first: the MEM-stage instruction is older than the fetch.
                if (D_wr) begin
                    state_d = StWrite;
                    owner_d = 1'b1;
                    base_d  = D_addr & BlockMask;
                end else if (D_miss) begin
                    state_d = StFill;
                    owner_d = 1'b1;
                    base_d  = D_addr & BlockMask;
                end else if (I_miss) begin
                    state_d = StFill;
                    owner_d = 1'b0;
                    base_d  = I_addr & BlockMask;
                end
            end
            StWrite: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = D_addr;
                mem_data_in = D_wdata;
                D_done      = 1'b1;
                state_d     = StIdle;
            end
            StFill: begin
                if (iss_q < IssEnd) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + (16'(iss_q) << 1);  // wraps mod 2^16
                    iss_d    = iss_q + 1'b1;
                end
                if (mem_data_valid) begin
                    fill_word = ret_q[WordW-1:0];
                    D_data_we = owner_q;
                    I_data_we = ~owner_q;
                    ret_d     = ret_q + 1'b1;
                    if (ret_q == RetLast) begin
                        state_d = StTag;
                    end
                end
            end
            StTag: begin
                D_tag_we = owner_q;
                I_tag_we = ~owner_q;
                D_done   = owner_q;
                I_done   = ~owner_q;
                iss_d    = '0;
                ret_d    = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign fill_data = mem_data_out;

    // Stalls are combinational so the pipeline holds in the cycle the request rises.
    assign I_stall = I_miss & ~I_done;
    assign D_stall = (D_miss | D_wr) & ~D_done;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: a latency-4 memory model plus a
// transaction-level scoreboard that predicts every output cycle by cycle.
module tb_cache_mem_arbiter;

    localparam int unsigned WORDS = 8;
    localparam int          LAT   = 4;
    localparam int          NCYC  = 4000;

    logic        clk;
    logic        rst_n;
    logic        I_miss;
    logic [15:0] I_addr;
    logic        D_miss;
    logic        D_wr;
    logic [15:0] D_addr;
    logic [15:0] D_wdata;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        I_data_we;
    logic        D_data_we;
    logic        I_tag_we;
    logic        D_tag_we;
    logic        I_stall;
    logic        D_stall;
    logic        I_done;
    logic        D_done;

    cache_mem_arbiter #(.WORDS(WORDS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .I_miss         (I_miss),
        .I_addr         (I_addr),
        .D_miss         (D_miss),
        .D_wr           (D_wr),
        .D_addr         (D_addr),
        .D_wdata        (D_wdata),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .I_data_we      (I_data_we),
        .D_data_we      (D_data_we),
        .I_tag_we       (I_tag_we),
        .D_tag_we       (D_tag_we),
        .I_stall        (I_stall),
        .D_stall        (D_stall),
        .I_done         (I_done),
        .D_done         (D_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int cyc;

    // Memory model: pending returns indexed by cycle modulo 16.
    logic        rv[0:15];
    logic [15:0] rd[0:15];

    // Scoreboard: current service (0 none, 1 store, 2 fill).
    int          m_kind;
    int          m_t;
    int          m_free;
    logic        m_own;   // 1: D
    logic [15:0] m_base;
    logic [15:0] m_waddr;
    logic [15:0] m_wdata;

    logic i_done_seen;
    logic d_done_seen;
    logic did_reset;
    int   quiet;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(3))
            0:       return 16'h0046;
            1:       return 16'h1234;
            2:       return 16'hFFF8;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic fill_active(input int c);
        return (m_kind == 2) && (c > m_t) && (c < m_t + 13);
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_quiet_outs(input string tag);
        check_eq({tag, "_mem_en"}, 16'(mem_en), 16'd0);
        check_eq({tag, "_mem_wr"}, 16'(mem_wr), 16'd0);
        check_eq({tag, "_mem_addr"}, mem_addr, 16'd0);
        check_eq({tag, "_mem_data_in"}, mem_data_in, 16'd0);
        check_eq({tag, "_fill_word"}, 16'(fill_word), 16'd0);
        check_eq({tag, "_strobes"},
                 16'({I_data_we, D_data_we, I_tag_we, D_tag_we, I_done, D_done}), 16'd0);
    endtask

    // Predict this cycle's outputs from the active transaction and compare.
    task automatic check_cycle();
        logic [15:0] e_addr, e_wdata, e_fdata;
        logic        e_en, e_wr, e_idwe, e_ddwe, e_itag, e_dtag, e_idone, e_ddone;
        int          e_fw, k;
        e_addr = 16'd0; e_wdata = 16'd0; e_fdata = 16'd0;
        e_en = 1'b0; e_wr = 1'b0; e_idwe = 1'b0; e_ddwe = 1'b0;
        e_itag = 1'b0; e_dtag = 1'b0; e_idone = 1'b0; e_ddone = 1'b0;
        e_fw = 0;
        k = cyc - m_t;
        if (m_kind == 1 && k == 1) begin
            e_en = 1'b1; e_wr = 1'b1; e_addr = m_waddr; e_wdata = m_wdata; e_ddone = 1'b1;
        end else if (m_kind == 2 && k >= 1 && k <= 13) begin
            if (k <= int'(WORDS)) begin
                e_en   = 1'b1;
                e_addr = m_base + 16'(2 * (k - 1));
            end
            if (k >= 1 + LAT && k <= LAT + int'(WORDS)) begin
                e_fw    = k - 1 - LAT;
                e_fdata = mem_word(m_base + 16'(2 * e_fw));
                e_ddwe  = m_own;
                e_idwe  = ~m_own;
            end
            if (k == LAT + int'(WORDS) + 1) begin
                e_dtag = m_own; e_itag = ~m_own; e_ddone = m_own; e_idone = ~m_own;
            end
        end
        check_eq("mem_en", 16'(mem_en), 16'(e_en));
        check_eq("mem_wr", 16'(mem_wr), 16'(e_wr));
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_data_in", mem_data_in, e_wdata);
        check_eq("I_data_we", 16'(I_data_we), 16'(e_idwe));
        check_eq("D_data_we", 16'(D_data_we), 16'(e_ddwe));
        check_eq("I_tag_we", 16'(I_tag_we), 16'(e_itag));
        check_eq("D_tag_we", 16'(D_tag_we), 16'(e_dtag));
        check_eq("I_done", 16'(I_done), 16'(e_idone));
        check_eq("D_done", 16'(D_done), 16'(e_ddone));
        check_eq("I_stall", 16'(I_stall), 16'(I_miss & ~e_idone));
        check_eq("D_stall", 16'(D_stall), 16'((D_miss | D_wr) & ~e_ddone));
        if (e_idwe || e_ddwe) begin
            check_eq("fill_word", 16'(fill_word), 16'(e_fw));
            check_eq("fill_data", fill_data, e_fdata);
        end
        if (e_itag || e_dtag) check_eq("tag_fill_word", 16'(fill_word), 16'd0);
    endtask

    // Grant decision taken by the scoreboard when idle, on this cycle's requests.
    task automatic arbitrate();
        if (D_wr) begin
            m_kind = 1; m_t = cyc; m_free = cyc + 2; m_own = 1'b1;
            m_waddr = D_addr; m_wdata = D_wdata;
        end else if (D_miss || I_miss) begin
            m_kind = 2; m_t = cyc; m_free = cyc + LAT + int'(WORDS) + 2;
            m_own  = D_miss;
            m_base = (D_miss ? D_addr : I_addr) & ~16'(2 * WORDS - 1);
        end else begin
            m_kind = 0;
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        I_miss = 1'b0; I_addr = 16'd0; D_miss = 1'b0; D_wr = 1'b0;
        D_addr = 16'd0; D_wdata = 16'd0; mem_data_out = 16'd0; mem_data_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin rv[i] = 1'b0; rd[i] = 16'd0; end
        m_kind = 0; m_t = 0; m_free = 0; m_own = 1'b0;
        m_base = 16'd0; m_waddr = 16'd0; m_wdata = 16'd0;
        i_done_seen = 1'b0; d_done_seen = 1'b0; did_reset = 1'b0; quiet = 0;

        // Reset values, and stalls following their inputs while in reset.
        @(negedge clk);
        check_quiet_outs("rst");
        check_eq("rst_I_stall", 16'(I_stall), 16'd0);
        I_miss = 1'b1; D_wr = 1'b1; mem_data_valid = 1'b1;
        #1;
        check_quiet_outs("rst_req");
        check_eq("rst_I_stall_follow", 16'(I_stall), 16'd1);
        check_eq("rst_D_stall_follow", 16'(D_stall), 16'd1);
        I_miss = 1'b0; D_wr = 1'b0; mem_data_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) rst_n = 1'b1;
            // Memory returns, plus stray valid pulses while no fill is live.
            if (rv[cyc & 15]) begin
                mem_data_valid = 1'b1;
                mem_data_out   = rd[cyc & 15];
                rv[cyc & 15]   = 1'b0;
            end else begin
                mem_data_valid = !fill_active(cyc) && ($urandom_range(3) == 0);
                mem_data_out   = 16'($urandom);
            end
            // Requesters: drop the cycle after done, otherwise raise at random.
            if (i_done_seen) begin
                I_miss = 1'b0; i_done_seen = 1'b0;
            end else if (!I_miss && quiet == 0 && $urandom_range(5) == 0) begin
                I_miss = 1'b1; I_addr = rand_addr();
            end
            if (d_done_seen) begin
                D_miss = 1'b0; D_wr = 1'b0; d_done_seen = 1'b0;
            end else if (!D_miss && !D_wr && quiet == 0 && $urandom_range(5) == 0) begin
                if ($urandom_range(1) == 1) D_wr = 1'b1;
                else D_miss = 1'b1;
                D_addr = rand_addr(); D_wdata = 16'($urandom);
            end
            if (quiet > 0) quiet--;

            @(negedge clk);
            check_cycle();
            if (I_done) i_done_seen = 1'b1;
            if (D_done) d_done_seen = 1'b1;
            if (mem_en && !mem_wr) begin
                rv[(cyc + LAT) & 15] = 1'b1;
                rd[(cyc + LAT) & 15] = mem_word(mem_addr);
            end
            if (cyc >= m_free) arbitrate();

            // Abort a fill with three words returned; late returns must be ignored.
            if (!did_reset && n > NCYC / 2 && m_kind == 2 && cyc - m_t == 3 + LAT + 1) begin
                rst_n = 1'b0;
                #1;
                check_quiet_outs("midfill_rst");
                check_eq("midfill_I_stall", 16'(I_stall), 16'(I_miss));
                check_eq("midfill_D_stall", 16'(D_stall), 16'(D_miss | D_wr));
                I_miss = 1'b0; D_miss = 1'b0; D_wr = 1'b0;
                i_done_seen = 1'b0; d_done_seen = 1'b0;
                m_kind = 0; m_free = cyc + 1; quiet = 10; did_reset = 1'b1;
            end
        end

        check_eq("reset_injected", 16'(did_reset), 16'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
